multicycle_ctrl: RTL and testbench

//  Multicycle control FSM for the Filter-GPU ARM-subset core: sequences one shared ALU/memory datapath per instruction.

---
 rtl/ctrl_pkg.sv | 52 +++++
 rtl/cond_check.sv | 36 +++
 rtl/multicycle_ctrl.sv | 150 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit.
package ctrl_pkg;

  localparam int unsigned FLAG_W = 4;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecR,
    StExecI,
    StAluWb,
    StBranch
  } state_t;

  // instr[27:26] classes
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Condition codes, instr[31:28]
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam logic [3:0] CMD_CMP = 4'b1010;

  // Mux selects
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCB_RD2      = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;
  localparam logic [1:0] IMM_BR        = 2'b10;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation against NZCV; cond 1111 never passes.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  // Decode condition code into pass/fail
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences the shared datapath, owns the NZCV register.
// Optional build macro MULTICYCLE_MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall on mem_ready.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        op,
  input  logic [5:0]        funct,
  input  logic [3:0]        rd,
  input  logic [3:0]        cond,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              adr_src,
  output logic              ir_write,
  output logic              mem_w,
  output logic              reg_w,
  output logic [1:0]        result_src,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        imm_src,
  output logic [1:0]        reg_src,
  output logic              alu_op,
  output logic [FLAG_W-1:0] flags,
  output logic              illegal_op
);

  state_t            state_q;
  logic [FLAG_W-1:0] flags_q;
  logic              cond_ex;
  logic              mem_ok;
  logic              is_cmp;
  logic              pc_dest;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  assign is_cmp  = (funct[4:1] == CMD_CMP);
  assign pc_dest = (rd == 4'd15);

  cond_check u_cond_check (
    .cond    (cond),
    .nzcv    (flags_q[3:0]),
    .cond_ex (cond_ex)
  );

  // State sequencing and flag capture in EXEC when S is set
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      flags_q <= '0;
    end else begin
      case (state_q)
        StFetch:  if (mem_ok) state_q <= StDecode;
        StDecode: begin
          if (!cond_ex || op == 2'b11) begin
            state_q <= StFetch;
          end else if (op == OP_DP) begin
            state_q <= funct[5] ? StExecI : StExecR;
          end else if (op == OP_MEM) begin
            state_q <= StMemAdr;
          end else begin
            state_q <= StBranch;
          end
        end
        StMemAdr: state_q <= funct[0] ? StMemRd : StMemWr;
        StMemRd:  if (mem_ok) state_q <= StMemWb;
        StMemWr:  if (mem_ok) state_q <= StFetch;
        StExecR, StExecI: begin
          state_q <= StAluWb;
          if (funct[0]) flags_q <= alu_flags;
        end
        default:  state_q <= StFetch;
      endcase
    end
  end

  // Moore output decode; reset blanks everything in the same cycle
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RD2;
    imm_src    = 2'b00;
    reg_src    = 2'b00;
    alu_op     = 1'b0;
    illegal_op = 1'b0;
    flags      = rst ? '0 : flags_q;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          ir_write   = mem_ok;
          pc_write   = mem_ok;
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURESULT;
        end
        StDecode: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURESULT;
          // RA2 from Rd for stores, RA1 from PC for branches
          reg_src    = {(op == OP_MEM) && !funct[0], op == OP_BR};
          illegal_op = (op == 2'b11);
        end
        StMemAdr: alu_src_b = SRCB_IMM;
        StMemRd:  adr_src = 1'b1;
        StMemWb: begin
          result_src = RES_DATA;
          reg_w      = 1'b1;
          pc_write   = pc_dest;
        end
        StMemWr: begin
          adr_src = 1'b1;
          mem_w   = mem_ok;
        end
        StExecR: alu_op = 1'b1;
        StExecI: begin
          alu_op    = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        StAluWb: begin
          result_src = RES_ALUOUT;
          reg_w      = !is_cmp;
          pc_write   = pc_dest && !is_cmp;
        end
        StBranch: begin
          alu_src_b  = SRCB_IMM;
          imm_src    = IMM_BR;
          result_src = RES_ALURESULT;
          pc_write   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: latency table, corner sequences, random model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cond, alu_flags, flags;
  logic       mem_ready;
  logic       pc_write, adr_src, ir_write, mem_w, reg_w, alu_src_a, alu_op, illegal_op;
  logic [1:0] result_src, alu_src_b, imm_src, reg_src;

  int checks = 0;
  int errors = 0;

`ifdef MULTICYCLE_MEM_WAIT_EN
  localparam bit WaitEn = 1'b1;
`else
  localparam bit WaitEn = 1'b0;
`endif

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .rd(rd), .cond(cond),
    .alu_flags(alu_flags), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .ir_write(ir_write), .mem_w(mem_w), .reg_w(reg_w), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_src(reg_src),
    .alu_op(alu_op), .flags(flags), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {pc_write, adr_src, ir_write, mem_w, reg_w, result_src, alu_src_a, alu_src_b,
            imm_src, reg_src, alu_op, illegal_op};
  endfunction

  function automatic logic [15:0] mk(bit pc, bit adr, bit ir, bit mw, bit rw, logic [1:0] rs,
                                     bit a, logic [1:0] b, logic [1:0] is, logic [1:0] regs,
                                     bit aop, bit ill);
    return {pc, adr, ir, mw, rw, rs, a, b, is, regs, aop, ill};
  endfunction

  // ARM condition semantics from the architecture's definitions
  function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (c == 4'hE);
    endcase
    return c[0] ? !base : base;
  endfunction

  // Reference model: expected per-cycle outputs for one whole instruction
  typedef struct {
    logic [15:0] v;
    bit          waitable;
    bit          setf;
  } step_t;
  step_t      q[$];
  logic [3:0] flags_m;

  task automatic push(logic [15:0] v, bit w, bit s);
    step_t st;
    st.v = v; st.waitable = w; st.setf = s;
    q.push_back(st);
  endtask

  task automatic build();
    bit taken, cmp, pcd;
    cmp   = (funct[4:1] == 4'b1010);
    pcd   = (rd == 4'd15);
    taken = cond_ok(cond, flags_m) && op != 2'b11;
    push(mk(1, 0, 1, 0, 0, 2'd2, 1, 2'd2, 0, 0, 0, 0), 1, 0);
    push(mk(0, 0, 0, 0, 0, 2'd2, 1, 2'd2, 0, {op == 2'b01 && !funct[0], op == 2'b10}, 0,
            op == 2'b11), 0, 0);
    if (taken) begin
      if (op == 2'b00) begin
        push(mk(0, 0, 0, 0, 0, 0, 0, {1'b0, funct[5]}, 0, 0, 1, 0), 0, funct[0]);
        push(mk(pcd && !cmp, 0, 0, 0, !cmp, 2'd0, 0, 0, 0, 0, 0, 0), 0, 0);
      end else if (op == 2'b01) begin
        push(mk(0, 0, 0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0), 0, 0);
        if (funct[0]) begin
          push(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0);
          push(mk(pcd, 0, 0, 0, 1, 2'd1, 0, 0, 0, 0, 0, 0), 0, 0);
        end else begin
          push(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0);
        end
      end else begin
        push(mk(1, 0, 0, 0, 0, 2'd2, 0, 2'd1, 2'd2, 0, 0, 0), 0, 0);
      end
    end
  endtask

  task automatic apply(logic [1:0] o, logic [5:0] f, logic [3:0] r, logic [3:0] c);
    op = o; funct = f; rd = r; cond = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cond;
    int         cyc, rw, pw, mw;
  } vec_t;
  vec_t tbl[10];

  logic [3:0] pat_pc, pat_ir;

  initial begin
    // flags are 0 after reset for every table row
    tbl[0] = '{"add",      2'b00, 6'b001000, 4'd1,  4'hE, 4, 1, 1, 0};
    tbl[1] = '{"cmp",      2'b00, 6'b010101, 4'd0,  4'hE, 4, 0, 1, 0};
    tbl[2] = '{"add_pc",   2'b00, 6'b101000, 4'd15, 4'hE, 4, 1, 2, 0};
    tbl[3] = '{"ldr_pc",   2'b01, 6'b011001, 4'd15, 4'hE, 5, 1, 2, 0};
    tbl[4] = '{"str",      2'b01, 6'b011000, 4'd3,  4'hE, 4, 0, 1, 1};
    tbl[5] = '{"b",        2'b10, 6'b000000, 4'd0,  4'hE, 3, 0, 2, 0};
    tbl[6] = '{"beq_fail", 2'b10, 6'b000000, 4'd0,  4'h0, 2, 0, 1, 0};
    tbl[7] = '{"cond_nv",  2'b00, 6'b001000, 4'd1,  4'hF, 2, 0, 1, 0};
    tbl[8] = '{"illegal",  2'b11, 6'b001000, 4'd1,  4'hE, 2, 0, 1, 0};
    tbl[9] = '{"addne",    2'b00, 6'b001000, 4'd1,  4'h1, 4, 1, 1, 0};

    rst = 1'b1; mem_ready = 1'b1; alu_flags = 4'hF;
    apply(2'b01, 6'b011000, 4'd15, 4'hE);
    @(negedge clk);
    chk("reset_outputs", {16'h0, dut_vec()}, 32'h0);
    chk("reset_flags", {28'h0, flags}, 32'h0);
    tick();

    // Latency and strobe counts per instruction class
    alu_flags = 4'h0;
    for (int i = 0; i < 10; i++) begin
      int cyc, rw, pw, mw;
      do_reset();
      apply(tbl[i].op, tbl[i].funct, tbl[i].rd, tbl[i].cond);
      cyc = 0; rw = 0; pw = 0; mw = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (k == 0) chk({tbl[i].name, "_first_fetch"}, {31'h0, ir_write}, 32'h1);
        if (k > 0 && ir_write) break;
        cyc++; rw += int'(reg_w); pw += int'(pc_write); mw += int'(mem_w);
        tick();
      end
      chk({tbl[i].name, "_cycles"}, cyc, tbl[i].cyc);
      chk({tbl[i].name, "_reg_w"}, rw, tbl[i].rw);
      chk({tbl[i].name, "_pc_write"}, pw, tbl[i].pw);
      chk({tbl[i].name, "_mem_w"}, mw, tbl[i].mw);
    end
    tick();

    // SUBS sets flags at the end of EXEC
    do_reset();
    apply(2'b00, 6'b000101, 4'd1, 4'hE);
    alu_flags = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 2) chk("subs_flags_exec", {28'h0, flags}, 32'h0);
      if (k == 3) begin
        chk("subs_flags_wb", {28'h0, flags}, 32'h4);
        chk("subs_reg_w", {31'h0, reg_w}, 32'h1);
      end
      tick();
    end
    alu_flags = 4'h0;
    // BEQ taken on Z=1: F, D, BRANCH
    apply(2'b10, 6'b000000, 4'd0, 4'h0);
    pat_pc = '0; pat_ir = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pat_pc[k] = pc_write; pat_ir[k] = ir_write;
      tick();
    end
    chk("beq_pc_write", {28'h0, pat_pc}, 32'h5);
    chk("beq_ir_write", {28'h0, pat_ir}, 32'h1);
    // BNE with Z=1 falls back to FETCH after DECODE
    apply(2'b10, 6'b000000, 4'd0, 4'h1);
    pat_pc = '0; pat_ir = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      pat_pc[k] = pc_write; pat_ir[k] = ir_write;
      tick();
    end
    chk("bne_pc_write", {28'h0, pat_pc}, 32'h1);
    chk("bne_ir_write", {28'h0, pat_ir}, 32'h1);
    // STR interrupted by reset in MEMWR; flags still 0100 here
    apply(2'b01, 6'b011000, 4'd2, 4'hE);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) chk("str_fetch_after_bne", {31'h0, ir_write}, 32'h1);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_memwr_mem_w", {31'h0, mem_w}, 32'h0);
    chk("rst_memwr_flags", {28'h0, flags}, 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_then_fetch", {31'h0, ir_write}, 32'h1);
    chk("rst_flags_cleared", {28'h0, flags}, 32'h0);
    tick();

`ifdef MULTICYCLE_MEM_WAIT_EN
    // LDR with memory stalled three cycles in MEMRD
    do_reset();
    apply(2'b01, 6'b011001, 4'd1, 4'hE);
    begin
      int cyc;
      cyc = 0;
      for (int k = 0; k < 20; k++) begin
        mem_ready = !(k >= 3 && k <= 5);
        @(negedge clk);
        if (k > 0 && ir_write) break;
        cyc++;
        tick();
      end
      chk("ldr_wait_cycles", cyc, 8);
    end
    mem_ready = 1'b1;
    tick();
`endif

    // Randomized run against the instruction-level model
    do_reset();
    q.delete();
    flags_m = '0;
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] exp;
      rst = ($urandom_range(0, 49) == 0);
      if (q.size() == 0) begin
        apply(2'($urandom), 6'($urandom), ($urandom_range(0, 1) == 0) ? 4'd15 : 4'($urandom),
              ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom));
        build();
      end
      alu_flags = 4'($urandom);
      mem_ready = WaitEn ? ($urandom_range(0, 3) != 0) : 1'($urandom);
      @(negedge clk);
      exp = q[0].v;
      if (q[0].waitable && WaitEn && !mem_ready) exp &= ~16'hB000;
      if (rst) exp = '0;
      chk("rand_outputs", {16'h0, dut_vec()}, {16'h0, exp});
      chk("rand_flags", {28'h0, flags}, rst ? 32'h0 : {28'h0, flags_m});
      if (rst) begin
        q.delete();
        flags_m = '0;
      end else if (!(q[0].waitable && WaitEn && !mem_ready)) begin
        if (q[0].setf) flags_m = alu_flags;
        void'(q.pop_front());
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
